tag_ram_ctrl: RTL and testbench
===============================

Name: tag_ram_ctrl

Overview:
- Initiator-side controller for the L1.5 icache single-port tag memory; drives its req/write/addr/wdata and consumes rdata.
- Arbitrates among three sources: full flush (invalidate sweep), refill tag write and hit/miss lookup.
- Performs an automatic invalidate sweep after reset.
- Sits between the cache controller FSM and the tag memory instance.

Parameters:
- TAG_ADDR_WIDTH, 6, index width; the memory holds 2**TAG_ADDR_WIDTH entries.
- TAG_WIDTH, 6, stored tag width.
- TAG_DATA_WIDTH, TAG_WIDTH+1 (TAG_WIDTH+2 with parity), memory word width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush_req_i  in  1  flush request level; hold until flush_ack_o.
- flush_ack_o  out  1  one-cycle pulse when an explicit flush completes.
- refill_req_i  in  1  write a valid tag.
- refill_gnt_o  out  1  refill accepted this cycle.
- refill_index_i  in  TAG_ADDR_WIDTH  refill index.
- refill_tag_i  in  TAG_WIDTH  refill tag.
- lookup_req_i  in  1  lookup request.
- lookup_gnt_o  out  1  lookup accepted this cycle.
- lookup_index_i  in  TAG_ADDR_WIDTH  lookup index.
- lookup_tag_i  in  TAG_WIDTH  tag to compare.
- lookup_rvalid_o  out  1  lookup result valid.
- lookup_hit_o  out  1  hit; qualified by lookup_rvalid_o.
- parity_err_o  out  1  parity mismatch pulse (optional feature only; tied 0 otherwise).
- busy_o  out  1  high in any state except IDLE.
- tag_req_o  out  1  memory request.
- tag_write_o  out  1  memory write enable.
- tag_addr_o  out  TAG_ADDR_WIDTH  memory address.
- tag_wdata_o  out  TAG_DATA_WIDTH  memory write data.
- tag_rdata_i  in  TAG_DATA_WIDTH  memory read data; valid the cycle after a read request.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Memory word layout: bit[TAG_WIDTH] = valid; bits[TAG_WIDTH-1:0] = tag.
- Reset values: state=INIT, sweep counter=0, flush_ack_o=0, lookup_rvalid_o=0, lookup_hit_o=0, parity_err_o=0. All combinational outputs evaluate to 0 in INIT.
- FSM states:
  - INIT: no memory access; next state FLUSH_AUTO.
  - FLUSH_AUTO / FLUSH_EXT:
    - Each cycle: tag_req_o=1, tag_write_o=1, tag_addr_o=counter, tag_wdata_o=0; counter increments.
    - On the write to address 2**TAG_ADDR_WIDTH-1, the counter wraps to 0 and the next state is IDLE.
    - FLUSH_EXT additionally registers flush_ack_o=1 for exactly the first IDLE cycle. FLUSH_AUTO never acks.
  - IDLE: fixed priority flush > refill > lookup, all evaluated combinationally in the same cycle.
    - flush_req_i=1: next state FLUSH_EXT, both grants 0. flush_req_i is ignored in the cycle flush_ack_o=1.
    - Otherwise, refill_req_i=1: refill_gnt_o=1; tag_req_o=1, tag_write_o=1, addr=refill_index_i, wdata={1'b1, refill_tag_i}.
    - Otherwise, lookup_req_i=1: lookup_gnt_o=1; tag_req_o=1, tag_write_o=0, addr=lookup_index_i. lookup_tag_i is registered.
- Lookup response:
  - Exactly 1 cycle after the grant: lookup_rvalid_o=1 and lookup_hit_o = rdata valid bit AND (rdata tag == registered tag).
  - Fully pipelined: one lookup per cycle.
  - A response in flight is still delivered even if the state moves to FLUSH_EXT in the same cycle.
- Grants are 0 in every state except IDLE; busy_o = (state != IDLE).
- Read-after-write ordering: a lookup granted the cycle after a refill to the same index observes the new tag (memory ordering; no forwarding).
- Reset mid-flush: the sweep restarts from address 0 in FLUSH_AUTO; the pending response and ack are discarded.

Optional Feature:
- Macro: HIER_ICACHE_TAG_PARITY_EN.
- Enabled:
  - TAG_DATA_WIDTH = TAG_WIDTH+2; bit[TAG_WIDTH+1] = XOR of bits[TAG_WIDTH:0] on writes. Flush writes all-zero, which is consistent parity.
  - On a lookup response, a recomputed parity mismatch forces lookup_hit_o=0 and pulses parity_err_o=1 in the lookup_rvalid_o cycle.
- Disabled: word is TAG_WIDTH+1 bits; parity_err_o is tied 0.

Test Plan (TAG_ADDR_WIDTH=6, TAG_WIDTH=6):
- Release reset: 1 INIT cycle, then 64 consecutive writes to addr 0..63 with wdata 0; busy_o low from the following cycle; flush_ack_o never asserts.
- Refill index 5, tag 0x2A; next cycle lookup index 5, tag 0x2A → rvalid+hit=1 one cycle later. Lookup with tag 0x15 → rvalid=1, hit=0.
- refill_req and lookup_req in the same IDLE cycle → refill_gnt_o=1, lookup_gnt_o=0. Lookups on 3 consecutive cycles → 3 consecutive rvalid cycles.
- flush_req_i raised with a lookup granted the same cycle → that response delivered; 64 writes; 1-cycle flush_ack_o; then lookup index 5, tag 0x2A → hit=0.
- Assert rst when the sweep reaches addr 20 → next sweep starts at addr 0 after INIT; no ack.
- With HIER_ICACHE_TAG_PARITY_EN: refill index 7, tag 0x01; force one tag_rdata_i bit flipped on lookup → hit=0, parity_err_o pulses 1 cycle.

Source files
------------

// File: rtl/tag_ram_ctrl.sv
// tag_ram_ctrl: initiator-side controller for the L1.5 icache single-port tag RAM.
// It arbitrates among a full invalidate sweep (flush), refill tag writes and
// hit/miss lookups. It also performs an automatic invalidate sweep after reset.
//
// Optional feature macro: HIER_ICACHE_TAG_PARITY_EN
//   When this macro is defined, each stored word carries an even-parity bit above
//   the valid bit. A parity mismatch on a lookup response forces a miss and
//   pulses parity_err_o. When it is undefined, parity_err_o is tied to 0.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   flush_req_i/ack_o  explicit flush request (level) / one-cycle completion pulse
//   refill_*           refill request, grant, index and tag
//   lookup_*           lookup request, grant, index, tag, result valid and hit
//   parity_err_o       parity mismatch pulse, qualified by lookup_rvalid_o
//   busy_o             high whenever the controller is not IDLE
//   tag_*              tag memory request, write enable, address, write data and
//                      read data (read data arrives one cycle after a read request)
module tag_ram_ctrl #(
  parameter int TAG_ADDR_WIDTH = 6,
  parameter int TAG_WIDTH      = 6,
`ifdef HIER_ICACHE_TAG_PARITY_EN
  localparam int TAG_DATA_WIDTH = TAG_WIDTH + 2
`else
  localparam int TAG_DATA_WIDTH = TAG_WIDTH + 1
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_req_i,
  output logic                      flush_ack_o,
  input  logic                      refill_req_i,
  output logic                      refill_gnt_o,
  input  logic [TAG_ADDR_WIDTH-1:0] refill_index_i,
  input  logic [TAG_WIDTH-1:0]      refill_tag_i,
  input  logic                      lookup_req_i,
  output logic                      lookup_gnt_o,
  input  logic [TAG_ADDR_WIDTH-1:0] lookup_index_i,
  input  logic [TAG_WIDTH-1:0]      lookup_tag_i,
  output logic                      lookup_rvalid_o,
  output logic                      lookup_hit_o,
  output logic                      parity_err_o,
  output logic                      busy_o,
  output logic                      tag_req_o,
  output logic                      tag_write_o,
  output logic [TAG_ADDR_WIDTH-1:0] tag_addr_o,
  output logic [TAG_DATA_WIDTH-1:0] tag_wdata_o,
  input  logic [TAG_DATA_WIDTH-1:0] tag_rdata_i
);

  typedef enum logic [1:0] {
    INIT,
    FLUSH_AUTO,
    FLUSH_EXT,
    IDLE
  } state_t;

  state_t                    state;
  logic [TAG_ADDR_WIDTH-1:0] sweep_cnt;
  logic [TAG_WIDTH-1:0]      lookup_tag_q;

  logic                      flush_take;
  logic                      refill_take;
  logic                      lookup_take;
  logic                      sweep_last;
  logic [TAG_WIDTH:0]        refill_body;
  logic [TAG_DATA_WIDTH-1:0] refill_word;
  logic                      rd_valid;
  logic [TAG_WIDTH-1:0]      rd_tag;
  logic                      rd_par_err;

  // Fixed-priority arbitration, only in IDLE. A flush request that is still
  // high in the ack cycle belongs to the flush that just finished, so it is ignored.
  always_comb begin
    flush_take  = 1'b0;
    refill_take = 1'b0;
    lookup_take = 1'b0;
    if (state == IDLE) begin
      if (flush_req_i && !flush_ack_o) begin
        flush_take = 1'b1;
      end else if (refill_req_i) begin
        refill_take = 1'b1;
      end else if (lookup_req_i) begin
        lookup_take = 1'b1;
      end
    end
  end

  assign sweep_last  = (sweep_cnt == '1);
  assign refill_body = {1'b1, refill_tag_i};

  assign rd_valid = tag_rdata_i[TAG_WIDTH];
  assign rd_tag   = tag_rdata_i[TAG_WIDTH-1:0];

`ifdef HIER_ICACHE_TAG_PARITY_EN
  // Even parity over the full word: a clean word (including all-zero) XORs to 0.
  assign refill_word  = {^refill_body, refill_body};
  assign rd_par_err   = ^tag_rdata_i;
  assign parity_err_o = lookup_rvalid_o & rd_par_err;
`else
  assign refill_word  = refill_body;
  assign rd_par_err   = 1'b0;
  assign parity_err_o = 1'b0;
`endif

  // The hit is evaluated on the read data in the response cycle and is
  // gated by the registered valid, so it is 0 whenever no response is due.
  assign lookup_hit_o = lookup_rvalid_o & rd_valid & (rd_tag == lookup_tag_q) & ~rd_par_err;

  assign refill_gnt_o = refill_take;
  assign lookup_gnt_o = lookup_take;
  assign busy_o       = (state != IDLE);

  always_comb begin
    tag_req_o   = 1'b0;
    tag_write_o = 1'b0;
    tag_addr_o  = '0;
    tag_wdata_o = '0;
    unique case (state)
      FLUSH_AUTO, FLUSH_EXT: begin
        tag_req_o   = 1'b1;
        tag_write_o = 1'b1;
        tag_addr_o  = sweep_cnt;
      end
      IDLE: begin
        if (refill_take) begin
          tag_req_o   = 1'b1;
          tag_write_o = 1'b1;
          tag_addr_o  = refill_index_i;
          tag_wdata_o = refill_word;
        end else if (lookup_take) begin
          tag_req_o  = 1'b1;
          tag_addr_o = lookup_index_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= INIT;
      sweep_cnt       <= '0;
      flush_ack_o     <= 1'b0;
      lookup_rvalid_o <= 1'b0;
      lookup_tag_q    <= '0;
    end else begin
      flush_ack_o <= 1'b0;
      // The response pipeline does not depend on the state. This lets a lookup
      // granted just before a flush still deliver its result.
      lookup_rvalid_o <= lookup_take;
      if (lookup_take) begin
        lookup_tag_q <= lookup_tag_i;
      end
      unique case (state)
        INIT: state <= FLUSH_AUTO;
        FLUSH_AUTO, FLUSH_EXT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_last) begin
            state       <= IDLE;
            flush_ack_o <= (state == FLUSH_EXT);
          end
        end
        IDLE: begin
          if (flush_take) begin
            state <= FLUSH_EXT;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Self-checking bench for tag_ram_ctrl. The bench contains a behavioural tag
// RAM that is driven by the DUT memory port. A separate reference array is
// updated from the intended refills and flushes. Lookup expectations are queued
// when the lookup is granted. A monitor pops and compares them when
// lookup_rvalid_o appears.
module tb_tag_ram_ctrl;
  localparam int AW = 6;
  localparam int TW = 6;
`ifdef HIER_ICACHE_TAG_PARITY_EN
  localparam int DW = TW + 2;
`else
  localparam int DW = TW + 1;
`endif
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_req_i = 1'b0;
  logic          flush_ack_o;
  logic          refill_req_i = 1'b0;
  logic          refill_gnt_o;
  logic [AW-1:0] refill_index_i = '0;
  logic [TW-1:0] refill_tag_i = '0;
  logic          lookup_req_i = 1'b0;
  logic          lookup_gnt_o;
  logic [AW-1:0] lookup_index_i = '0;
  logic [TW-1:0] lookup_tag_i = '0;
  logic          lookup_rvalid_o;
  logic          lookup_hit_o;
  logic          parity_err_o;
  logic          busy_o;
  logic          tag_req_o;
  logic          tag_write_o;
  logic [AW-1:0] tag_addr_o;
  logic [DW-1:0] tag_wdata_o;
  logic [DW-1:0] tag_rdata_i;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  tag_ram_ctrl #(.TAG_ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .refill_req_i(refill_req_i), .refill_gnt_o(refill_gnt_o),
    .refill_index_i(refill_index_i), .refill_tag_i(refill_tag_i),
    .lookup_req_i(lookup_req_i), .lookup_gnt_o(lookup_gnt_o),
    .lookup_index_i(lookup_index_i), .lookup_tag_i(lookup_tag_i),
    .lookup_rvalid_o(lookup_rvalid_o), .lookup_hit_o(lookup_hit_o),
    .parity_err_o(parity_err_o), .busy_o(busy_o),
    .tag_req_o(tag_req_o), .tag_write_o(tag_write_o),
    .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o),
    .tag_rdata_i(tag_rdata_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port tag RAM. Read data is registered, and it can be
  // corrupted in the top bit on request.
  logic [DW-1:0] mem [DEPTH];
  logic          flip_next = 1'b0;
  logic [DW-1:0] flip_mask;
  assign flip_mask = {1'b1, {(DW-1){1'b0}}};
  always @(posedge clk) begin
    if (tag_req_o) begin
      if (tag_write_o) mem[tag_addr_o] <= tag_wdata_o;
      else tag_rdata_i <= mem[tag_addr_o] ^ (flip_next ? flip_mask : '0);
    end
  end

  // Reference contents.
  bit            ref_valid [DEPTH];
  logic [TW-1:0] ref_tag   [DEPTH];

  typedef struct {
    logic        hit;
    logic        perr;
    int unsigned due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic logic [DW-1:0] exp_word(input logic [TW-1:0] t);
    logic [TW:0] b;
    b = {1'b1, t};
`ifdef HIER_ICACHE_TAG_PARITY_EN
    return {^b, b};
`else
    return b;
`endif
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic push_lookup(input logic [AW-1:0] idx, input logic [TW-1:0] t, input bit corrupt);
    exp_t e;
    e.hit  = corrupt ? 1'b0 : (ref_valid[idx] && ref_tag[idx] == t);
    e.perr = corrupt;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (lookup_rvalid_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected cycle=%0d rvalid=1 required=0", cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.due != cyc || lookup_hit_o !== mon_e.hit || parity_err_o !== mon_e.perr) begin
            errors++;
            $display("FAIL rsp cycle=%0d hit=%b perr=%b required cycle=%0d hit=%b perr=%b",
                     cyc, lookup_hit_o, parity_err_o, mon_e.due, mon_e.hit, mon_e.perr);
          end
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing cycle=%0d rvalid=0 required=1", cyc);
        void'(sb.pop_front());
      end
      if (!lookup_rvalid_o && (lookup_hit_o !== 1'b0 || parity_err_o !== 1'b0)) begin
        checks++;
        errors++;
        $display("FAIL rsp_unqualified hit=%b perr=%b required 0 0", lookup_hit_o, parity_err_o);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'($urandom);
      mem[i][TW] = 1'b1;
    end
    clear_ref();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (tag_req_o !== 1'b0 || flush_ack_o !== 1'b0 || lookup_rvalid_o !== 1'b0 ||
        refill_gnt_o !== 1'b0 || lookup_gnt_o !== 1'b0 || lookup_hit_o !== 1'b0 || parity_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs req=%b ack=%b rvalid=%b rgnt=%b lgnt=%b required all 0",
               tag_req_o, flush_ack_o, lookup_rvalid_o, refill_gnt_o, lookup_gnt_o);
    end
    adv();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tag_req_o !== 1'b0 || tag_write_o !== 1'b0) begin
      errors++;
      $display("FAIL init_no_access req=%b we=%b required 0 0", tag_req_o, tag_write_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      adv();
      @(negedge clk);
      checks++;
      if (tag_req_o !== 1'b1 || tag_write_o !== 1'b1 || tag_addr_o !== AW'(i) ||
          tag_wdata_o !== '0 || flush_ack_o !== 1'b0 || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL auto_sweep req=%b we=%b addr=%0d wdata=%h ack=%b busy=%b required 1 1 %0d 0 0 1",
                 tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o, flush_ack_o, busy_o, i);
      end
    end
    adv();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || flush_ack_o !== 1'b0 || tag_req_o !== 1'b0) begin
      errors++;
      $display("FAIL auto_sweep_done busy=%b ack=%b req=%b required 0 0 0", busy_o, flush_ack_o, tag_req_o);
    end
  endtask

  task automatic test_refill_lookup();
    adv();
    refill_req_i = 1'b1; refill_index_i = 6'd5; refill_tag_i = 6'h2A;
    @(negedge clk);
    checks++;
    if (refill_gnt_o !== 1'b1 || tag_req_o !== 1'b1 || tag_write_o !== 1'b1 ||
        tag_addr_o !== 6'd5 || tag_wdata_o !== exp_word(6'h2A)) begin
      errors++;
      $display("FAIL refill_write gnt=%b req=%b we=%b addr=%0d wdata=%h required 1 1 1 5 %h",
               refill_gnt_o, tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o, exp_word(6'h2A));
    end
    ref_valid[5] = 1'b1; ref_tag[5] = 6'h2A;
    adv();
    refill_req_i = 1'b0;
    lookup_req_i = 1'b1; lookup_index_i = 6'd5; lookup_tag_i = 6'h2A;
    @(negedge clk);
    checks++;
    if (lookup_gnt_o !== 1'b1 || tag_req_o !== 1'b1 || tag_write_o !== 1'b0 || tag_addr_o !== 6'd5) begin
      errors++;
      $display("FAIL lookup_read gnt=%b req=%b we=%b addr=%0d required 1 1 0 5",
               lookup_gnt_o, tag_req_o, tag_write_o, tag_addr_o);
    end
    push_lookup(6'd5, 6'h2A, 1'b0);
    adv();
    lookup_tag_i = 6'h15;
    @(negedge clk);
    checks++;
    if (lookup_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL lookup_miss_gnt gnt=%b required 1", lookup_gnt_o);
    end
    push_lookup(6'd5, 6'h15, 1'b0);
    adv();
    lookup_req_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priority();
    adv();
    refill_req_i = 1'b1; refill_index_i = 6'd9; refill_tag_i = 6'h33;
    lookup_req_i = 1'b1; lookup_index_i = 6'd9; lookup_tag_i = 6'h33;
    @(negedge clk);
    checks++;
    if (refill_gnt_o !== 1'b1 || lookup_gnt_o !== 1'b0 || tag_write_o !== 1'b1) begin
      errors++;
      $display("FAIL refill_over_lookup rgnt=%b lgnt=%b we=%b required 1 0 1",
               refill_gnt_o, lookup_gnt_o, tag_write_o);
    end
    ref_valid[9] = 1'b1; ref_tag[9] = 6'h33;
    adv();
    refill_req_i = 1'b0;
    lookup_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] idx [3];
    logic [TW-1:0] tg  [3];
    idx[0] = 6'd5; tg[0] = 6'h2A;
    idx[1] = 6'd9; tg[1] = 6'h33;
    idx[2] = 6'd3; tg[2] = 6'h00;
    for (int k = 0; k < 3; k++) begin
      adv();
      lookup_req_i = 1'b1; lookup_index_i = idx[k]; lookup_tag_i = tg[k];
      @(negedge clk);
      checks++;
      if (lookup_gnt_o !== 1'b1 || tag_addr_o !== idx[k]) begin
        errors++;
        $display("FAIL b2b_gnt k=%0d gnt=%b addr=%0d required 1 %0d", k, lookup_gnt_o, tag_addr_o, idx[k]);
      end
      push_lookup(idx[k], tg[k], 1'b0);
    end
    adv();
    lookup_req_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flush_ext();
    adv();
    lookup_req_i = 1'b1; lookup_index_i = 6'd5; lookup_tag_i = 6'h2A;
    @(negedge clk);
    checks++;
    if (lookup_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush_lookup gnt=%b required 1", lookup_gnt_o);
    end
    push_lookup(6'd5, 6'h2A, 1'b0);
    adv();
    lookup_req_i = 1'b0;
    flush_req_i = 1'b1;
    refill_req_i = 1'b1; refill_index_i = 6'd11; refill_tag_i = 6'h11;
    @(negedge clk);
    checks++;
    if (refill_gnt_o !== 1'b0 || lookup_gnt_o !== 1'b0 || tag_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_priority rgnt=%b lgnt=%b req=%b required 0 0 0",
               refill_gnt_o, lookup_gnt_o, tag_req_o);
    end
    refill_req_i = 1'b0;
    clear_ref();
    for (int i = 0; i < DEPTH; i++) begin
      adv();
      @(negedge clk);
      checks++;
      if (tag_req_o !== 1'b1 || tag_write_o !== 1'b1 || tag_addr_o !== AW'(i) ||
          tag_wdata_o !== '0 || flush_ack_o !== 1'b0 || busy_o !== 1'b1 || lookup_gnt_o !== 1'b0) begin
        errors++;
        $display("FAIL ext_sweep req=%b we=%b addr=%0d wdata=%h ack=%b busy=%b required 1 1 %0d 0 0 1",
                 tag_req_o, tag_write_o, tag_addr_o, tag_wdata_o, flush_ack_o, busy_o, i);
      end
    end
    adv();
    @(negedge clk);
    checks++;
    if (flush_ack_o !== 1'b1 || busy_o !== 1'b0 || tag_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack ack=%b busy=%b req=%b required 1 0 0", flush_ack_o, busy_o, tag_req_o);
    end
    adv();
    flush_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (flush_ack_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack_single ack=%b busy=%b required 0 0", flush_ack_o, busy_o);
    end
    adv();
    lookup_req_i = 1'b1; lookup_index_i = 6'd5; lookup_tag_i = 6'h2A;
    @(negedge clk);
    checks++;
    if (lookup_gnt_o !== 1'b1) begin
      errors++;
      $display("FAIL post_flush_lookup gnt=%b required 1", lookup_gnt_o);
    end
    push_lookup(6'd5, 6'h2A, 1'b0);
    adv();
    lookup_req_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    bit found;
    found = 1'b0;
    adv();
    flush_req_i = 1'b1;
    for (int k = 0; k < 100 && !found; k++) begin
      adv();
      @(negedge clk);
      if (busy_o && tag_write_o && tag_addr_o == 6'd20) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_flush_reach addr20_seen=0 required 1");
    end
    rst = 1'b1;
    flush_req_i = 1'b0;
    #1;
    sb.delete();
    clear_ref();
    checks++;
    if (tag_req_o !== 1'b0 || flush_ack_o !== 1'b0 || lookup_rvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs req=%b ack=%b rvalid=%b required 0 0 0",
               tag_req_o, flush_ack_o, lookup_rvalid_o);
    end
    adv();
    adv();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tag_req_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_init req=%b required 0", tag_req_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      adv();
      @(negedge clk);
      checks++;
      if (tag_req_o !== 1'b1 || tag_write_o !== 1'b1 || tag_addr_o !== AW'(i) || flush_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL restart_sweep req=%b we=%b addr=%0d ack=%b required 1 1 %0d 0",
                 tag_req_o, tag_write_o, tag_addr_o, flush_ack_o, i);
      end
    end
    adv();
    @(negedge clk);
    checks++;
    if (flush_ack_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL restart_no_ack ack=%b busy=%b required 0 0", flush_ack_o, busy_o);
    end
  endtask

`ifdef HIER_ICACHE_TAG_PARITY_EN
  task automatic test_parity();
    adv();
    refill_req_i = 1'b1; refill_index_i = 6'd7; refill_tag_i = 6'h01;
    @(negedge clk);
    checks++;
    if (refill_gnt_o !== 1'b1 || tag_wdata_o !== exp_word(6'h01)) begin
      errors++;
      $display("FAIL parity_refill gnt=%b wdata=%h required 1 %h", refill_gnt_o, tag_wdata_o, exp_word(6'h01));
    end
    ref_valid[7] = 1'b1; ref_tag[7] = 6'h01;
    adv();
    refill_req_i = 1'b0;
    lookup_req_i = 1'b1; lookup_index_i = 6'd7; lookup_tag_i = 6'h01;
    flip_next = 1'b1;
    @(negedge clk);
    push_lookup(6'd7, 6'h01, 1'b1);
    adv();
    flip_next = 1'b0;
    @(negedge clk);
    push_lookup(6'd7, 6'h01, 1'b0);
    adv();
    lookup_req_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_refill_lookup();
    test_priority();
    test_back_to_back();
    test_flush_ext();
`ifdef HIER_ICACHE_TAG_PARITY_EN
    test_parity();
`endif
    test_reset_mid_flush();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time_limit_reached required finish");
    $fatal(1, "watchdog");
  end

endmodule
